// File: rtl/cell_mem_arbiter.sv
// Interpreter cell store shared by the parser (port 0) and evaluator (port 1).
// Serves read/write/alloc/free one at a time; alloc pops a cdr-threaded free list, else bumps.
module cell_mem_arbiter #(
  parameter int NUM_CELLS   = 256,
  parameter int TYPE_WIDTH  = 5,
  parameter int VALUE_WIDTH = 16,
  localparam int WORD_SIZE  = TYPE_WIDTH + 2 * VALUE_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          req_valid,
  input  logic [1:0][1:0]                     req_op,
  input  logic [1:0][VALUE_WIDTH-1:0]         req_addr,
  input  logic [1:0][WORD_SIZE-1:0]           req_wdata,
  output logic [1:0]                          req_ready,
  output logic [1:0]                          rsp_valid,
  output logic [WORD_SIZE-1:0]                rsp_rdata,
  output logic [VALUE_WIDTH-1:0]              rsp_addr,
  output logic [2:0]                          rsp_err,
  output logic [VALUE_WIDTH:0]                used_count
);

  localparam int IDX_W = (NUM_CELLS > 2) ? $clog2(NUM_CELLS) : 1;
  localparam logic [VALUE_WIDTH:0] NUM_CELLS_W = (VALUE_WIDTH + 1)'(NUM_CELLS);
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FREE  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_POP = 2'd2, ST_RESP = 2'd3} state_t;
  typedef enum logic [2:0] {ERR_NONE = 3'd0, ERR_MEM_FULL = 3'd1, ERR_MEM_USED = 3'd2} err_t;

  state_t                 state_r, state_n_s;
  logic                   grant_s, accept_s, rr_last_r;
  logic                   cmd_id_r;
  logic [1:0]             cmd_op_r;
  logic [VALUE_WIDTH-1:0] cmd_addr_r;
  logic [WORD_SIZE-1:0]   cmd_wdata_r;
  logic [VALUE_WIDTH-1:0] free_head_r, pop_next_r;
  logic [VALUE_WIDTH:0]   bump_r, used_count_r;
  logic [NUM_CELLS-1:0]   used_r;
  logic [WORD_SIZE-1:0]   mem [0:NUM_CELLS-1];
  logic [1:0]             rsp_valid_r;
  logic [WORD_SIZE-1:0]   rsp_rdata_r;
  logic [VALUE_WIDTH-1:0] rsp_addr_r;
  err_t                   rsp_err_r;
  logic [IDX_W-1:0]       cmd_idx_s, free_idx_s, bump_idx_s;
  logic                   addr_ok_s, fl_empty_s, bump_full_s;
  logic [1:0]             rsp_onehot_s;

  assign cmd_idx_s    = cmd_addr_r[IDX_W-1:0];
  assign free_idx_s   = free_head_r[IDX_W-1:0];
  assign bump_idx_s   = bump_r[IDX_W-1:0];
  // Range check guards the truncated bitmap index.
  assign addr_ok_s    = (cmd_addr_r != {VALUE_WIDTH{1'b0}}) && ({1'b0, cmd_addr_r} < NUM_CELLS_W)
                        && used_r[cmd_idx_s];
  assign fl_empty_s   = (free_head_r == {VALUE_WIDTH{1'b0}});
  assign bump_full_s  = (bump_r >= NUM_CELLS_W);
  assign rsp_onehot_s = cmd_id_r ? 2'b10 : 2'b01;

  // Round-robin arbitration, only while idle.
  always_comb begin
    grant_s  = 1'b0;
    accept_s = 1'b0;
    if ((state_r == ST_IDLE) && (req_valid != 2'b00)) begin
      accept_s = 1'b1;
      if (req_valid == 2'b11) begin
        grant_s = ~rr_last_r;
      end else begin
        grant_s = req_valid[1];
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  assign req_ready = accept_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: state_n_s = accept_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_n_s = (cmd_op_r == 2'b10 && !fl_empty_s) ? ST_POP : ST_RESP;
      ST_POP:  state_n_s = ST_RESP;
      ST_RESP: state_n_s = ST_IDLE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_n_s;
  end

  // Command capture, allocator bookkeeping and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_r    <= 1'b1;
      cmd_id_r     <= 1'b0;
      cmd_op_r     <= 2'b00;
      cmd_addr_r   <= {VALUE_WIDTH{1'b0}};
      cmd_wdata_r  <= {WORD_SIZE{1'b0}};
      free_head_r  <= {VALUE_WIDTH{1'b0}};
      pop_next_r   <= {VALUE_WIDTH{1'b0}};
      bump_r       <= (VALUE_WIDTH + 1)'(1);
      used_r       <= {NUM_CELLS{1'b0}};
      used_count_r <= {(VALUE_WIDTH + 1){1'b0}};
      rsp_valid_r  <= 2'b00;
      rsp_rdata_r  <= {WORD_SIZE{1'b0}};
      rsp_addr_r   <= {VALUE_WIDTH{1'b0}};
      rsp_err_r    <= ERR_NONE;
    end else begin
      rsp_valid_r <= 2'b00;
      if (accept_s) begin
        cmd_id_r    <= grant_s;
        cmd_op_r    <= req_op[grant_s];
        cmd_addr_r  <= req_addr[grant_s];
        cmd_wdata_r <= req_wdata[grant_s];
        rr_last_r   <= grant_s;
      end
      case (state_r)
        ST_EXEC: begin
          rsp_valid_r <= rsp_onehot_s;
          rsp_rdata_r <= {WORD_SIZE{1'b0}};
          rsp_addr_r  <= {VALUE_WIDTH{1'b0}};
          rsp_err_r   <= ERR_MEM_USED;
          case (cmd_op_r)
            OP_READ: if (addr_ok_s) begin
              rsp_rdata_r <= mem[cmd_idx_s];
              rsp_addr_r  <= cmd_addr_r;
              rsp_err_r   <= ERR_NONE;
            end
            OP_WRITE: if (addr_ok_s) begin
              rsp_addr_r <= cmd_addr_r;
              rsp_err_r  <= ERR_NONE;
            end
            OP_FREE: if (addr_ok_s) begin
              free_head_r         <= cmd_addr_r;
              used_r[cmd_idx_s]   <= 1'b0;
              used_count_r        <= used_count_r - (VALUE_WIDTH + 1)'(1);
              rsp_addr_r          <= cmd_addr_r;
              rsp_err_r           <= ERR_NONE;
            end
            default: begin
              if (!fl_empty_s) begin
                pop_next_r  <= mem[free_idx_s][VALUE_WIDTH-1:0];
                rsp_valid_r <= 2'b00;
              end else if (!bump_full_s) begin
                used_r[bump_idx_s] <= 1'b1;
                used_count_r       <= used_count_r + (VALUE_WIDTH + 1)'(1);
                rsp_addr_r         <= bump_r[VALUE_WIDTH-1:0];
                bump_r             <= bump_r + (VALUE_WIDTH + 1)'(1);
                rsp_err_r          <= ERR_NONE;
              end else begin
                rsp_err_r <= ERR_MEM_FULL;
              end
            end
          endcase
        end
        ST_POP: begin
          free_head_r        <= pop_next_r;
          used_r[free_idx_s] <= 1'b1;
          used_count_r       <= used_count_r + (VALUE_WIDTH + 1)'(1);
          rsp_valid_r        <= rsp_onehot_s;
          rsp_rdata_r        <= {WORD_SIZE{1'b0}};
          rsp_addr_r         <= free_head_r;
          rsp_err_r          <= ERR_NONE;
        end
        default: ;
      endcase
    end
  end

  // Cell storage; contents survive reset, writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state_r)
        ST_EXEC: begin
          if (cmd_op_r == OP_WRITE && addr_ok_s) begin
            mem[cmd_idx_s] <= cmd_wdata_r;
          end else if (cmd_op_r == OP_FREE && addr_ok_s) begin
            mem[cmd_idx_s] <= {{TYPE_WIDTH{1'b0}}, {VALUE_WIDTH{1'b0}}, free_head_r};
          end else if (cmd_op_r == 2'b10 && fl_empty_s && !bump_full_s) begin
            mem[bump_idx_s] <= {WORD_SIZE{1'b0}};
          end
        end
        ST_POP:  mem[free_idx_s] <= {WORD_SIZE{1'b0}};
        default: ;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign rsp_addr   = rsp_addr_r;
  assign rsp_err    = rsp_err_r;
  assign used_count = used_count_r;

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Directed bench for cell_mem_arbiter with an 8-cell store so the full condition is reachable.
module tb_cell_mem_arbiter;
  localparam int NC = 8;
  localparam int VW = 16;
  localparam int WS = 37;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, AL = 2'b10, FR = 2'b11;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0][1:0]     req_op;
  logic [1:0][VW-1:0]  req_addr;
  logic [1:0][WS-1:0]  req_wdata;
  logic [1:0]          req_ready, rsp_valid;
  logic [WS-1:0]       rsp_rdata;
  logic [VW-1:0]       rsp_addr;
  logic [2:0]          rsp_err;
  logic [VW:0]         used_count;

  int tests_run = 0;
  int tests_failed = 0;

  cell_mem_arbiter #(.NUM_CELLS(NC), .TYPE_WIDTH(5), .VALUE_WIDTH(VW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .used_count(used_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    req_op = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one command on a port; returns latency from accept to response.
  task automatic issue(input int port, input logic [1:0] op, input logic [VW-1:0] addr,
                       input logic [WS-1:0] wdata, output int lat, output logic [VW-1:0] raddr,
                       output logic [WS-1:0] rdata, output logic [2:0] err);
    bit acc = 0;
    bit got = 0;
    lat = 0; raddr = '0; rdata = '0; err = 3'd7;
    @(posedge clk); #1;
    req_valid[port] = 1'b1;
    req_op[port] = op;
    req_addr[port] = addr;
    req_wdata[port] = wdata;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (req_ready[port]) acc = 1;
    end
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
    check_eq("accept", 64'(acc), 64'd1);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[port]) begin
        got = 1;
        raddr = rsp_addr;
        rdata = rsp_rdata;
        err = rsp_err;
      end
    end
    check_eq("response", 64'(got), 64'd1);
  endtask

  task automatic run_op(input string tag, input int port, input logic [1:0] op,
                        input logic [VW-1:0] addr, input logic [WS-1:0] wdata, input int exp_lat,
                        input logic [VW-1:0] exp_addr, input logic [WS-1:0] exp_rdata,
                        input logic [2:0] exp_err);
    int lat;
    logic [VW-1:0] ra;
    logic [WS-1:0] rd;
    logic [2:0] er;
    issue(port, op, addr, wdata, lat, ra, rd, er);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_addr"}, 64'(ra), 64'(exp_addr));
    check_eq({tag, "_rdata"}, 64'(rd), 64'(exp_rdata));
    check_eq({tag, "_err"}, 64'(er), 64'(exp_err));
  endtask

  initial begin
    int grants[$];
    int rsp_port[$];
    int rsp_adr[$];
    bit seen;

    do_reset();
    @(negedge clk);
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_addr", 64'(rsp_addr), 64'd0);
    check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("rst_err", 64'(rsp_err), 64'd0);
    check_eq("rst_count", 64'(used_count), 64'd0);

    // Bump allocation, write and read back.
    run_op("alloc1", 0, AL, 16'd0, 37'd0, 2, 16'd1, 37'd0, 3'd0);
    run_op("alloc2", 0, AL, 16'd0, 37'd0, 2, 16'd2, 37'd0, 3'd0);
    run_op("alloc3", 0, AL, 16'd0, 37'd0, 2, 16'd3, 37'd0, 3'd0);
    check_eq("count3", 64'(used_count), 64'd3);
    run_op("write1", 0, WR, 16'd1, {5'h02, 16'h0007, 16'h0000}, 2, 16'd1, 37'd0, 3'd0);
    run_op("read1", 0, RD, 16'd1, 37'd0, 2, 16'd1, 37'h02_0007_0000, 3'd0);

    // Free list: chain 2 -> 3, pops in LIFO order and clears reused cells.
    run_op("write2", 1, WR, 16'd2, 37'h1F_ABCD_1234, 2, 16'd2, 37'd0, 3'd0);
    run_op("free3", 0, FR, 16'd3, 37'd0, 2, 16'd3, 37'd0, 3'd0);
    run_op("free2", 0, FR, 16'd2, 37'd0, 2, 16'd2, 37'd0, 3'd0);
    check_eq("count1", 64'(used_count), 64'd1);
    run_op("pop2", 0, AL, 16'd0, 37'd0, 3, 16'd2, 37'd0, 3'd0);
    run_op("pop3", 1, AL, 16'd0, 37'd0, 3, 16'd3, 37'd0, 3'd0);
    run_op("read2", 0, RD, 16'd2, 37'd0, 2, 16'd2, 37'd0, 3'd0);
    run_op("alloc4", 0, AL, 16'd0, 37'd0, 2, 16'd4, 37'd0, 3'd0);
    check_eq("count4", 64'(used_count), 64'd4);

    // Invalid addresses leave state alone.
    run_op("rd_unalloc5", 0, RD, 16'd5, 37'd0, 2, 16'd0, 37'd0, 3'd2);
    run_op("free_nil", 0, FR, 16'd0, 37'd0, 2, 16'd0, 37'd0, 3'd2);
    run_op("rd_range9", 0, RD, 16'd9, 37'd0, 2, 16'd0, 37'd0, 3'd2);
    check_eq("count_err", 64'(used_count), 64'd4);
    run_op("free3b", 0, FR, 16'd3, 37'd0, 2, 16'd3, 37'd0, 3'd0);
    run_op("free3_dbl", 0, FR, 16'd3, 37'd0, 2, 16'd0, 37'd0, 3'd2);
    run_op("wr_freed3", 1, WR, 16'd3, 37'h5, 2, 16'd0, 37'd0, 3'd2);
    check_eq("count_dbl", 64'(used_count), 64'd3);

    // Exhaust the bump pointer.
    do_reset();
    for (int i = 1; i < NC; i++) begin
      run_op($sformatf("fill%0d", i), 0, AL, 16'd0, 37'd0, 2, VW'(i), 37'd0, 3'd0);
    end
    run_op("full", 0, AL, 16'd0, 37'd0, 2, 16'd0, 37'd0, 3'd1);
    check_eq("count_full", 64'(used_count), 64'd7);

    // Both requesters contend continuously.
    do_reset();
    req_op[0] = AL;
    req_op[1] = AL;
    req_valid = 2'b11;
    for (int c = 0; c < 60 && rsp_port.size() < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00 && grants.size() < 4) grants.push_back(int'(req_ready[1]));
      if (rsp_valid != 2'b00) begin
        rsp_port.push_back(int'(rsp_valid[1]));
        rsp_adr.push_back(int'(rsp_addr));
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check_eq("rr_ngrant", 64'(grants.size()), 64'd4);
    check_eq("rr_nrsp", 64'(rsp_port.size()), 64'd4);
    for (int i = 0; i < 4 && i < grants.size() && i < rsp_port.size(); i++) begin
      check_eq($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % 2));
      check_eq($sformatf("rr_port%0d", i), 64'(rsp_port[i]), 64'(i % 2));
      check_eq($sformatf("rr_addr%0d", i), 64'(rsp_adr[i]), 64'(i + 1));
    end
    repeat (4) @(posedge clk);

    // Reset while a command is in EXEC.
    do_reset();
    run_op("pre_a", 0, AL, 16'd0, 37'd0, 2, 16'd1, 37'd0, 3'd0);
    run_op("pre_b", 0, AL, 16'd0, 37'd0, 2, 16'd2, 37'd0, 3'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_op[0] = AL;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_ready[0]) seen = 1;
    end
    check_eq("mid_accept", 64'(seen), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1;
    end
    #1 rst = 1'b0;
    check_eq("mid_no_rsp", 64'(seen), 64'd0);
    check_eq("mid_count", 64'(used_count), 64'd0);
    run_op("post_rst", 0, AL, 16'd0, 37'd0, 2, 16'd1, 37'd0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
